// File: rtl/ram_access_unit.sv
// ram_access_unit
// ---------------
// Initiator for the single-port synchronous word RAM. Takes byte/half/word
// load and store requests over a valid/ready handshake. It drives the RAM's
// r_wn/address/data_in port and consumes its registered data_out. The RAM
// writes whole 32-bit words only, so byte and half stores are done as
// read-modify-write.
//
// Optional feature: define RAM_ACCESS_ALIGN_CHECK_EN to reject the following
// requests through a one-cycle error response:
//   - size 11,
//   - a half with addr[0] set,
//   - a word with addr[1:0] nonzero.
// When the macro is undefined, those offset bits are ignored, size 11 acts
// as a word, and resp_err is constant 0.
//
// Ports
//   clk, rst            rising-edge clock; synchronous active-high reset
//   req_valid/ready     request handshake (ready only in IDLE, rst low)
//   req_we              1 = store, 0 = load
//   req_addr            byte address (word index [ADDR_W+1:2], lane [1:0])
//   req_size            00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        load zero-extend (1) / sign-extend (0)
//   req_wdata           right-aligned store data
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load data (0 for stores/errors)
//   resp_err            rejected request, qualified by resp_valid
//   ram_r_wn            RAM control: 1 = read, 0 = write
//   ram_address         RAM word address
//   ram_data_in         RAM write data
//   ram_data_out        RAM registered read data
module ram_access_unit #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              ram_r_wn,
  output logic [ADDR_W-1:0] ram_address,
  output logic [31:0]       ram_data_in,
  input  logic [31:0]       ram_data_out
);

  typedef enum logic [2:0] {
    IDLE, LD_WAIT, LD_CAP, RMW_WAIT, RMW_MERGE, ST_WR, RESP
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e              state_q, state_d;
  logic [1:0]          size_q, size_d;
  logic [1:0]          lane_q, lane_d;
  logic                unsigned_q, unsigned_d;
  logic [15:0]         wdata_q, wdata_d;       // only sub-word stores need it
  logic                resp_valid_q, resp_valid_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;
  logic                ram_r_wn_q, ram_r_wn_d;
  logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
  logic [31:0]         ram_data_in_q, ram_data_in_d;

  logic                req_err;
  logic [1:0]          req_size_eff;

`ifdef RAM_ACCESS_ALIGN_CHECK_EN
  assign req_err = (req_size == 2'b11)
                 | ((req_size == SZ_HALF) & req_addr[0])
                 | ((req_size == SZ_WORD) & (|req_addr[1:0]));
  assign req_size_eff = req_size;
`else
  assign req_err      = 1'b0;
  assign req_size_eff = (req_size == 2'b11) ? SZ_WORD : req_size;
`endif

  // Pick the addressed lane out of a RAM word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: load_extend = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: load_extend = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  // Replace the addressed lane(s) of the old word with the new store data.
  function automatic logic [31:0] merge_lanes(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic [15:0] wdata);
    merge_lanes = word;
    if (size == SZ_BYTE) begin
      case (lane)
        2'd0:    merge_lanes[7:0]   = wdata[7:0];
        2'd1:    merge_lanes[15:8]  = wdata[7:0];
        2'd2:    merge_lanes[23:16] = wdata[7:0];
        default: merge_lanes[31:24] = wdata[7:0];
      endcase
    end else if (lane[1]) begin
      merge_lanes[31:16] = wdata;
    end else begin
      merge_lanes[15:0] = wdata;
    end
  endfunction

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d       = state_q;
    size_d        = size_q;
    lane_d        = lane_q;
    unsigned_d    = unsigned_q;
    wdata_d       = wdata_q;
    resp_valid_d  = 1'b0;              // RESP is one cycle; pulse ends by default
    resp_err_d    = 1'b0;
    resp_rdata_d  = resp_rdata_q;
    ram_r_wn_d    = 1'b1;              // the RAM writes on any edge with r_wn low
    ram_address_d = ram_address_q;
    ram_data_in_d = ram_data_in_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d        = req_size_eff;
          lane_d        = req_addr[1:0];
          unsigned_d    = req_unsigned;
          wdata_d       = req_wdata[15:0];
          ram_address_d = req_addr[ADDR_W+1:2];
          if (req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'b0;
          end else if (!req_we) begin
            state_d = LD_WAIT;
          end else if (req_size_eff == SZ_WORD) begin
            state_d       = ST_WR;
            ram_r_wn_d    = 1'b0;
            ram_data_in_d = req_wdata;
          end else begin
            state_d = RMW_WAIT;
          end
        end
      end
      LD_WAIT:  state_d = LD_CAP;      // RAM latches the address on this edge
      LD_CAP: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = load_extend(ram_data_out, size_q, lane_q, unsigned_q);
      end
      RMW_WAIT: state_d = RMW_MERGE;
      RMW_MERGE: begin
        state_d       = ST_WR;
        ram_r_wn_d    = 1'b0;
        ram_data_in_d = merge_lanes(ram_data_out, size_q, lane_q, wdata_q);
      end
      ST_WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'b0;
      end
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      size_q        <= SZ_BYTE;
      lane_q        <= 2'b0;
      unsigned_q    <= 1'b0;
      wdata_q       <= 16'b0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 32'b0;
      resp_err_q    <= 1'b0;
      ram_r_wn_q    <= 1'b1;
      ram_address_q <= '0;
      ram_data_in_q <= 32'b0;
    end else begin
      state_q       <= state_d;
      size_q        <= size_d;
      lane_q        <= lane_d;
      unsigned_q    <= unsigned_d;
      wdata_q       <= wdata_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
      ram_r_wn_q    <= ram_r_wn_d;
      ram_address_q <= ram_address_d;
      ram_data_in_q <= ram_data_in_d;
    end
  end

  assign req_ready   = (state_q == IDLE) && !rst;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign ram_r_wn    = ram_r_wn_q;
  assign ram_address = ram_address_q;
  assign ram_data_in = ram_data_in_q;

endmodule

// File: tb/tb_ram_access_unit.sv
// Testbench for ram_access_unit. A behavioural word RAM with a registered
// read port sits on the RAM side. A shadow memory plus shift/mask arithmetic
// predicts every response, its latency and the final memory contents.
module tb_ram_access_unit;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W+1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              ram_r_wn;
  logic [ADDR_W-1:0] ram_address;
  logic [31:0]       ram_data_in;
  logic [31:0]       ram_data_out;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  int n_checks  = 0;
  int n_errors  = 0;
  int wr_edges  = 0;

  always #5 clk = ~clk;

  ram_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .ram_r_wn     (ram_r_wn),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  // Single-port synchronous RAM, read-first, one-edge read latency.
  always @(posedge clk) begin
    if (!ram_r_wn) begin
      mem[ram_address] <= ram_data_in;
      wr_edges         <= wr_edges + 1;
    end
    ram_data_out <= mem[ram_address];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One complete request: predict, drive, wait for the response, compare.
  task automatic do_req(input logic we, input logic [ADDR_W+1:0] addr,
                        input logic [1:0] size, input logic uns,
                        input logic [31:0] wdata, input string tag);
    logic [31:0]       w, mask, exp_rdata;
    logic [ADDR_W-1:0] widx;
    logic [1:0]        sz;
    logic              exp_err;
    int                sh, exp_lat, exp_writes, lat, wr0, wait_cnt;

    widx    = addr[ADDR_W+1:2];
    sz      = size;
    exp_err = 1'b0;
`ifdef RAM_ACCESS_ALIGN_CHECK_EN
    exp_err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
`else
    if (size == 2'd3) sz = 2'd2;
`endif
    case (sz)
      2'd0:    begin mask = 32'h0000_00FF; sh = 8 * int'(addr[1:0]); end
      2'd1:    begin mask = 32'h0000_FFFF; sh = 16 * int'(addr[1]);  end
      default: begin mask = 32'hFFFF_FFFF; sh = 0;                   end
    endcase
    w         = ref_mem[widx];
    exp_rdata = 32'h0;
    if (exp_err) begin
      exp_lat = 0;
    end else if (!we) begin
      exp_lat   = 2;
      exp_rdata = (w >> sh) & mask;
      if (!uns && ((exp_rdata & ((mask >> 1) + 32'd1)) != 32'h0))
        exp_rdata = exp_rdata | ~mask;
    end else begin
      exp_lat       = (sz == 2'd2) ? 1 : 3;
      ref_mem[widx] = (w & ~(mask << sh)) | ((wdata & mask) << sh);
    end
    exp_writes = (we && !exp_err) ? 1 : 0;

    @(negedge clk);
    wait_cnt = 0;
    while (!req_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    check({tag, ":ready"}, {31'b0, req_ready}, 32'd1);
    wr0          = wr_edges;
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check({tag, ":busy"}, {31'b0, req_ready}, 32'd0);

    lat = 0;
    while (!resp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ":valid"}, {31'b0, resp_valid}, 32'd1);
    check({tag, ":latency"}, lat, exp_lat);
    check({tag, ":rdata"}, resp_rdata, exp_rdata);
    check({tag, ":err"}, {31'b0, resp_err}, {31'b0, exp_err});
    @(posedge clk);
    #1;
    check({tag, ":pulse"}, {31'b0, resp_valid}, 32'd0);
    check({tag, ":writes"}, wr_edges - wr0, exp_writes);
  endtask

  initial begin
    int wr0;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = '0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_wdata    = 32'h0;

    // Reset: two cycles held, then released.
    repeat (2) @(posedge clk);
    #1;
    check("rst:ready", {31'b0, req_ready}, 32'd0);
    check("rst:r_wn", {31'b0, ram_r_wn}, 32'd1);
    check("rst:valid", {31'b0, resp_valid}, 32'd0);
    check("rst:rdata", resp_rdata, 32'd0);
    check("rst:err", {31'b0, resp_err}, 32'd0);
    check("rst:addr", {20'b0, ram_address}, 32'd0);
    check("rst:data_in", ram_data_in, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst:ready_after", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end

    // Word store then word load.
    do_req(1'b1, 14'h010, 2'd2, 1'b0, 32'hDEADBEEF, "sw");
    do_req(1'b0, 14'h010, 2'd2, 1'b0, 32'h0, "lw");
    check("sw:ram_word4", mem[4], 32'hDEADBEEF);

    // Byte store into the top lane, then signed/unsigned byte loads.
    do_req(1'b1, 14'h010, 2'd2, 1'b0, 32'h11223344, "sw_init");
    do_req(1'b1, 14'h013, 2'd0, 1'b0, 32'h00000080, "sb");
    check("sb:ram_word4", mem[4], 32'h80223344);
    do_req(1'b0, 14'h013, 2'd0, 1'b0, 32'h0, "lb");
    do_req(1'b0, 14'h013, 2'd0, 1'b1, 32'h0, "lbu");

    // Half store into the upper half.
    do_req(1'b1, 14'h010, 2'd2, 1'b0, 32'h11223344, "sw_init2");
    do_req(1'b1, 14'h012, 2'd1, 1'b0, 32'h0000ABCD, "sh");
    check("sh:ram_word4", mem[4], 32'hABCD3344);

    // Misaligned word load (error path or lane-0 word, depending on build).
    do_req(1'b0, 14'h002, 2'd2, 1'b0, 32'h0, "lw_misalign");

    // Reset during RMW_MERGE of a byte store: no write, no response.
    do_req(1'b1, 14'h020, 2'd2, 1'b0, 32'h11223344, "sw_pre");
    @(negedge clk);
    wr0          = wr_edges;
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_addr     = 14'h021;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_wdata    = 32'h55;
    @(posedge clk);             // E0: accepted
    #1;
    req_valid = 1'b0;
    @(posedge clk);             // E1: now in RMW_MERGE
    #1;
    rst = 1'b1;
    @(posedge clk);             // E2: reset takes effect
    #1;
    check("abort:r_wn", {31'b0, ram_r_wn}, 32'd1);
    check("abort:valid", {31'b0, resp_valid}, 32'd0);
    check("abort:ready_in_rst", {31'b0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("abort:ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("abort:no_resp", {31'b0, resp_valid}, 32'd0);
    end
    check("abort:writes", wr_edges - wr0, 32'd0);
    check("abort:ram_word8", mem[8], 32'h11223344);
    do_req(1'b0, 14'h020, 2'd2, 1'b0, 32'h0, "abort_lw");

    // Randomised traffic over a small window so words get reused.
    for (int i = 0; i < 200; i++) begin
      logic [ADDR_W+1:0] a;
      a = '0;
      a[5:0] = 6'($urandom_range(0, 63));
      do_req(1'($urandom), a, 2'($urandom), 1'($urandom), $urandom, "rnd");
    end

    for (int i = 0; i < 16; i++)
      check("final:mem", mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
